regfield_port_arbiter: RTL and testbench
========================================

Name: regfield_port_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single read/write port of the tt_um_regfield register file among NREQ requesters, e.g. the pin-command decoder and an internal scan engine.
- Each requester gets a valid/ready request channel and a one-cycle response strobe.
- The block drives the register file port and absorbs its 1-cycle read latency.

Parameters:
- NREQ, 2, number of requesters (2..4)
- AW, 3, register address width
- DW, 8, register data width

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_we  in  NREQ  1 = write, 0 = read, per requester
- req_addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot acceptance
- rsp_valid  out  NREQ  one-hot, one-cycle completion strobe
- rsp_rdata  out  DW  read data; valid while rsp_valid is nonzero
- rf_en  out  1  register file port enable
- rf_we  out  1  register file write enable
- rf_addr  out  AW  register file address
- rf_wdata  out  DW  register file write data
- rf_rdata  in  DW  register file read data; valid the cycle after rf_en=1 with rf_we=0
- busy  out  1  high in any state other than IDLE

Behaviour:

Reset:
- Synchronous, evaluated only at the clock edge.
- After reset: state=IDLE; last_grant=NREQ-1, so requester 0 has first priority.
- All outputs 0, and the latched request registers are cleared.
- Reset mid-transaction abandons it: no rsp_valid pulse is produced.
- rf_en is 0 from the first cycle after the reset edge.

FSM states: IDLE, ISSUE, WAIT, RESP.

IDLE:
- Winner = first i with req_valid[i]=1, searching from last_grant+1 upward and wrapping modulo NREQ.
- req_ready[winner]=1 combinationally; all other req_ready bits are 0.
- If any req_valid is set: latch the winner's index, we, addr and wdata; go to ISSUE.
- Otherwise stay in IDLE.
- req_ready is 0 in every other state.

ISSUE:
- rf_en=1, rf_we=latched we, rf_addr and rf_wdata = latched values.
- Next state: RESP if write, WAIT if read.

WAIT:
- rf_en=0.
- Capture rf_rdata into the response register; go to RESP.

RESP:
- rsp_valid[owner]=1 for exactly one cycle.
- rsp_rdata = captured data for a read, 0 for a write.
- last_grant <= owner; go to IDLE.

Outside ISSUE, rf_en, rf_we, rf_addr and rf_wdata are all 0.

Latency from acceptance edge to rsp_valid:
- Write: rsp_valid asserted 2 cycles after acceptance.
- Read: rsp_valid asserted 3 cycles after acceptance.
- Maximum throughput: one write per 3 cycles, one read per 4 cycles.

Handshake:
- A transfer occurs on the edge where req_valid[i] and req_ready[i] are both 1.
- A requester may deassert valid before it is accepted; nothing is recorded.
- Request inputs are ignored after acceptance; the latched copy is used.
- Responses have no backpressure.

Fairness:
- A continuously asserted requester is served within NREQ transactions.
- With all requesters valid, service order is 0, 1, …, NREQ-1, 0, …

Simultaneous events:
- A new request arriving during RESP waits for IDLE.
- A requester may re-request in the IDLE cycle right after its own RESP, but it loses to any other pending requester.

Packed-field slicing and all widths are exact; no address range checks (AW covers the file).

Test Plan:
1. Reset, then req0 write addr=3 wdata=0xA5 → req_ready[0] high in the acceptance cycle. Next cycle rf_en=1, rf_we=1, rf_addr=3, rf_wdata=0xA5. One cycle later rsp_valid=01, rsp_rdata=0x00. busy high for exactly 2 cycles.
2. req1 read addr=3 with the model returning 0xA5 → rf_en=1, rf_we=0 one cycle after acceptance. rsp_valid=10 with rsp_rdata=0xA5 three cycles after acceptance.
3. Both requesters hold valid continuously with reads to addr 1 and 2 → grants alternate 0, 1, 0, 1. Each response carries its own address's data. A new grant is issued every 4 cycles.
4. Simultaneous first requests right after reset → requester 0 wins. After its RESP, requester 1 wins even though requester 0 re-asserts immediately.
5. Assert rst during WAIT of a read → no rsp_valid. Next cycle state=IDLE, rf_en=0, busy=0. A pending req0 is granted before req1, because last_grant was reset.
6. req0 raises valid for one cycle while busy with req1, then drops it → no transfer for req0 and no rsp_valid[0]. The arbiter returns to IDLE with busy=0.

Source files
------------

// File: rtl/regfield_port_arbiter.sv
// Round-robin arbiter that shares the single register-file port among NREQ
// requesters, sequencing each access and absorbing the one-cycle read latency.
module regfield_port_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 3,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rf_en,
    output logic               rf_we,
    output logic [AW-1:0]      rf_addr,
    output logic [DW-1:0]      rf_wdata,
    input  logic [DW-1:0]      rf_rdata,
    output logic               busy
);

    localparam int IW = $clog2(NREQ);
    localparam int SW = IW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   last_grant_reg, last_grant_next;
    logic [IW-1:0]   owner_reg, owner_next;
    logic            we_reg, we_next;
    logic [AW-1:0]   addr_reg, addr_next;
    logic [DW-1:0]   wdata_reg, wdata_next;
    logic [DW-1:0]   rdata_reg, rdata_next;

    logic [AW-1:0]   addr_arr  [NREQ];
    logic [DW-1:0]   wdata_arr [NREQ];
    logic [SW-1:0]   cand_sum  [NREQ];
    logic [IW-1:0]   cand_idx  [NREQ];
    logic [IW-1:0]   winner;
    logic            any_valid;

    // cand_idx[k] is the requester at priority rank k: last_grant+1+k modulo NREQ.
    // The sum never reaches 2*NREQ, so a single conditional subtract wraps it.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
            assign addr_arr[gi]  = req_addr[gi*AW +: AW];
            assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
            assign cand_sum[gi]  = {1'b0, last_grant_reg} + SW'(gi + 1);
            assign cand_idx[gi]  = (cand_sum[gi] >= SW'(NREQ))
                                 ? IW'(cand_sum[gi] - SW'(NREQ))
                                 : cand_sum[gi][IW-1:0];
        end
    endgenerate

    assign any_valid = |req_valid;

    // Scan from lowest priority to highest so the last hit is the winner.
    always_comb begin
        winner = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[cand_idx[k]]) begin
                winner = cand_idx[k];
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        owner_next      = owner_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        rdata_next      = rdata_reg;
        req_ready       = '0;
        rsp_valid       = '0;
        rsp_rdata       = '0;
        rf_en           = 1'b0;
        rf_we           = 1'b0;
        rf_addr         = '0;
        rf_wdata        = '0;

        case (state_reg)
            IDLE: begin
                if (any_valid) begin
                    req_ready[winner] = 1'b1;
                    owner_next        = winner;
                    we_next           = req_we[winner];
                    addr_next         = addr_arr[winner];
                    wdata_next        = wdata_arr[winner];
                    // Writes answer with zero data, so clear any stale read value.
                    rdata_next        = '0;
                    state_next        = ISSUE;
                end
            end
            ISSUE: begin
                rf_en      = 1'b1;
                rf_we      = we_reg;
                rf_addr    = addr_reg;
                rf_wdata   = wdata_reg;
                state_next = we_reg ? RESP : WAIT;
            end
            WAIT: begin
                rdata_next = rf_rdata;
                state_next = RESP;
            end
            RESP: begin
                rsp_valid[owner_reg] = 1'b1;
                rsp_rdata            = rdata_reg;
                last_grant_next      = owner_reg;
                state_next           = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= IW'(NREQ - 1);
            owner_reg      <= '0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            owner_reg      <= owner_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            rdata_reg      <= rdata_next;
        end
    end

    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_regfield_port_arbiter.sv
// Bench for regfield_port_arbiter: directed scenarios then random traffic, all
// checked each cycle against a transaction-level schedule and shadow memory.
module tb_regfield_port_arbiter;

    localparam int NREQ  = 2;
    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               rf_en;
    logic               rf_we;
    logic [AW-1:0]      rf_addr;
    logic [DW-1:0]      rf_wdata;
    logic [DW-1:0]      rf_rdata;
    logic               busy;

    regfield_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rf_en     (rf_en),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_wdata  (rf_wdata),
        .rf_rdata  (rf_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n = 0;

    // Reference schedule: cycle numbers at which the arbiter is next free,
    // drives the port, and answers the current transaction.
    int             idle_at;
    int             issue_at;
    int             resp_at;
    int             last_g;
    int             m_owner;
    logic           m_we;
    logic [AW-1:0]  m_addr;
    logic [DW-1:0]  m_wdata;
    logic [DW-1:0]  m_rdata;
    logic [DW-1:0]  shadow [DEPTH];

    logic [DW-1:0]  rfmem [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int lastg, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(lastg + k) % NREQ]) return (lastg + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // One clock cycle: check every output against the schedule, advance the
    // schedule across the edge, then play the register file's part.
    task automatic tick();
        logic [NREQ-1:0] e_ready;
        logic [NREQ-1:0] e_rsp;
        logic [DW-1:0]   e_rdata;
        logic            p_en;
        logic            p_we;
        logic [AW-1:0]   p_addr;
        logic [DW-1:0]   p_wdata;
        int              w;
        #1;
        e_ready = '0;
        e_rsp   = '0;
        e_rdata = '0;
        w       = -1;
        if (n == idle_at && req_valid != '0) begin
            w = rr_pick(last_g, req_valid);
            e_ready[w] = 1'b1;
        end
        if (n == resp_at) begin
            e_rsp[m_owner] = 1'b1;
            e_rdata        = m_rdata;
            $display("TXN cycle %0d req%0d %s addr %0d data %02h", n, m_owner,
                     m_we ? "write" : "read", m_addr, m_we ? m_wdata : m_rdata);
        end
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
        chk("busy",      32'(busy),      32'(n < idle_at));
        chk("rf_en",     32'(rf_en),     32'(n == issue_at));
        chk("rf_we",     32'(rf_we),     32'(n == issue_at && m_we));
        chk("rf_addr",   32'(rf_addr),   (n == issue_at) ? 32'(m_addr) : 32'd0);
        chk("rf_wdata",  32'(rf_wdata),  (n == issue_at) ? 32'(m_wdata) : 32'd0);

        p_en    = rf_en;
        p_we    = rf_we;
        p_addr  = rf_addr;
        p_wdata = rf_wdata;

        if (rst) begin
            idle_at  = n + 1;
            issue_at = -1;
            resp_at  = -1;
            last_g   = NREQ - 1;
        end else if (n == idle_at) begin
            if (w >= 0) begin
                m_owner  = w;
                m_we     = req_we[w];
                m_addr   = req_addr[w*AW +: AW];
                m_wdata  = req_wdata[w*DW +: DW];
                issue_at = n + 1;
                resp_at  = n + (m_we ? 2 : 3);
                idle_at  = resp_at + 1;
                last_g   = w;
                if (m_we) begin
                    m_rdata         = '0;
                    shadow[m_addr]  = m_wdata;
                end else begin
                    m_rdata = shadow[m_addr];
                end
            end else begin
                idle_at = n + 1;
            end
        end

        @(posedge clk);
        #1;
        if (p_en && p_we) rfmem[p_addr] = p_wdata;
        rf_rdata = (p_en && !p_we) ? rfmem[p_addr] : DW'($urandom);
        n++;
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            rfmem[a]  = DW'($urandom);
            shadow[a] = rfmem[a];
        end
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        rf_rdata  = DW'($urandom);
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        n        = 0;
        idle_at  = 0;
        issue_at = -1;
        resp_at  = -1;
        last_g   = NREQ - 1;

        // Reset state with nothing pending.
        tick();

        // Single write from requester 0.
        set_req(0, 1'b1, 1'b1, 3'd3, 8'hA5);
        tick();
        set_req(0, 1'b0, 1'b0, 3'd0, 8'h00);
        repeat (3) tick();

        // Read back through requester 1.
        set_req(1, 1'b1, 1'b0, 3'd3, 8'h00);
        tick();
        set_req(1, 1'b0, 1'b0, 3'd0, 8'h00);
        repeat (4) tick();

        // Both requesters reading continuously must alternate.
        set_req(0, 1'b1, 1'b0, 3'd1, 8'h00);
        set_req(1, 1'b1, 1'b0, 3'd2, 8'h00);
        repeat (17) tick();
        req_valid = '0;
        repeat (4) tick();

        // Simultaneous first requests right after a reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1'b1, 1'b1, 3'd4, 8'h3C);
        set_req(1, 1'b1, 1'b1, 3'd5, 8'hC3);
        repeat (7) tick();
        req_valid = '0;
        repeat (3) tick();

        // Reset during the wait cycle of a read abandons it.
        set_req(0, 1'b1, 1'b0, 3'd5, 8'h00);
        tick();
        set_req(0, 1'b0, 1'b0, 3'd0, 8'h00);
        tick();
        rst = 1'b1;
        set_req(0, 1'b1, 1'b0, 3'd4, 8'h00);
        set_req(1, 1'b1, 1'b0, 3'd3, 8'h00);
        tick();
        rst = 1'b0;
        repeat (9) tick();
        req_valid = '0;
        repeat (3) tick();

        // A one-cycle request while busy is never recorded.
        set_req(1, 1'b1, 1'b1, 3'd6, 8'h77);
        tick();
        set_req(1, 1'b0, 1'b0, 3'd0, 8'h00);
        set_req(0, 1'b1, 1'b1, 3'd7, 8'h11);
        tick();
        set_req(0, 1'b0, 1'b0, 3'd0, 8'h00);
        repeat (4) tick();

        // Random traffic, including drop-before-accept and occasional resets.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, ($urandom % 3) != 0, 1'($urandom % 2),
                        AW'($urandom), DW'($urandom));
            end
            rst = (($urandom % 80) == 0);
            tick();
        end
        rst       = 1'b0;
        req_valid = '0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
